lsu_misalign: RTL and testbench

- Load/store unit between the core's ALU/register file and the data memory.
- Decodes RV32I load/store funct3 and byte address into memory chip-select, write-enable, lane mask, word address and lane-aligned write data.
- Extracts and sign/zero-extends load data.
- Splits misaligned halfword/word accesses that cross a word boundary into two sequential word accesses, stalling the single-cycle core for one extra cycle.

---
 rtl/lsu_misalign_pkg.sv | 31 +++
 rtl/lsu_misalign_if.sv | 34 +++
 rtl/lsu_misalign_load_extend.sv | 32 +++
 rtl/lsu_misalign.sv | 110 +++++++++++
 tb/tb_lsu_misalign.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_misalign_pkg.sv
// Shared types for the load/store unit: RV32I funct3 codes, FSM states, access size decode.
package lsu_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd4,
    LHU = 3'd5
  } ld_funct3_e;

  typedef enum logic [2:0] {
    SB = 3'd0,
    SH = 3'd1,
    SW = 3'd2
  } st_funct3_e;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_e;

  function automatic logic [3:0] size_mask(input logic [2:0] funct3);
    case (funct3[1:0])
      2'd0:    size_mask = 4'b0001;
      2'd1:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_misalign_if.sv
// Core request/response and data-memory signals of the load/store unit.
interface lsu_if #(
  parameter int ADDR_W = 13
);
  logic              req_valid;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              stall;
  logic [31:0]       load_data;
  logic              ld_valid;
  logic              fault;
  logic              mem_cs;
  logic              mem_wr;
  logic [3:0]        mem_mask;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // Core plus data memory side.
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  stall, load_data, ld_valid, fault,
    input  mem_cs, mem_wr, mem_mask, mem_addr, mem_wdata
  );

  // Load/store unit side.
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output stall, load_data, ld_valid, fault,
    output mem_cs, mem_wr, mem_mask, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_misalign_load_extend.sv
// Selects the loaded bytes from a two-word window at byte offset off_i and sign/zero-extends them.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] lo_i,
  input  logic [23:0] hi_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] word;

  // Only the low 24 bits of the upper word can ever land in the result.
  always_comb begin
    case (off_i)
      2'd0:    word = lo_i;
      2'd1:    word = {hi_i[7:0],  lo_i[31:8]};
      2'd2:    word = {hi_i[15:0], lo_i[31:16]};
      default: word = {hi_i[23:0], lo_i[31:24]};
    endcase
  end

  always_comb begin
    case (funct3_i[1:0])
      2'd0:    data_o = funct3_i[2] ? {24'b0, word[7:0]}  : {{24{word[7]}}, word[7:0]};
      2'd1:    data_o = funct3_i[2] ? {16'b0, word[15:0]} : {{16{word[15]}}, word[15:0]};
      default: data_o = word;
    endcase
  end

endmodule

// File: rtl/lsu_misalign.sv
// RV32I load/store unit: decodes accesses onto a word memory, splitting word-crossing
// halfword/word accesses into two cycles (one stall) or faulting them when splitting is disabled.
module lsu_misalign
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 13,
  parameter int MISALIGN_EN = 1
) (
  input  logic  clk,
  input  logic  rst,
  lsu_if.slave  bus
);

  state_e      state_q, state_d;
  logic [31:0] hold_q, hold_d;

  logic [1:0]        off;
  logic [7:0]        lanes64;
  logic [ADDR_W-1:0] word_a;
  logic              crossing;
  logic              bad_f3;
  logic              out_of_range;
  logic              fault_c;
  logic [5:0]        sh_hi;
  logic [31:0]       ext_data;

  assign off          = bus.req_addr[1:0];
  assign lanes64      = {4'b0, size_mask(bus.req_funct3)} << off;
  assign word_a       = bus.req_addr[ADDR_W+1:2];
  assign crossing     = |lanes64[7:4];
  assign out_of_range = |bus.req_addr[31:ADDR_W+2];
  assign sh_hi        = 6'd32 - {1'b0, off, 3'b000};

  always_comb begin
    if (bus.req_we) bad_f3 = (bus.req_funct3 > SW);
    else            bad_f3 = (bus.req_funct3[1:0] == 2'b11) || (bus.req_funct3 == 3'b110);
  end

  // A crossing access at the last word would wrap to word 0, so it is rejected.
  assign fault_c = bad_f3 || out_of_range ||
                   (crossing && ((MISALIGN_EN == 0) || (&word_a)));

  lsu_load_extend u_ext (
    .lo_i     ((state_q == SECOND) ? hold_q : bus.mem_rdata),
    .hi_i     ((state_q == SECOND) ? bus.mem_rdata[23:0] : 24'b0),
    .off_i    (off),
    .funct3_i (bus.req_funct3),
    .data_o   (ext_data)
  );

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    bus.mem_cs    = 1'b1;
    bus.mem_wr    = 1'b1;
    bus.mem_mask  = 4'b0;
    bus.mem_addr  = word_a;
    bus.mem_wdata = 32'b0;
    bus.stall     = 1'b0;
    bus.ld_valid  = 1'b0;
    bus.fault     = 1'b0;

    if (rst && bus.req_valid) begin
      case (state_q)
        IDLE: begin
          if (fault_c) begin
            bus.fault = 1'b1;
          end else begin
            bus.mem_cs    = 1'b0;
            bus.mem_wr    = ~bus.req_we;
            bus.mem_wdata = bus.req_wdata << {off, 3'b000};
            if (crossing) begin
              bus.mem_mask = lanes64[3:0];
              bus.stall    = 1'b1;
              hold_d       = bus.mem_rdata;
              state_d      = SECOND;
            end else begin
              bus.mem_mask = bus.req_we ? lanes64[3:0] : 4'b0;
              bus.ld_valid = ~bus.req_we;
            end
          end
        end
        default: begin
          bus.mem_cs    = 1'b0;
          bus.mem_wr    = ~bus.req_we;
          bus.mem_addr  = word_a + ADDR_W'(1);
          bus.mem_mask  = lanes64[7:4];
          bus.mem_wdata = bus.req_wdata >> sh_hi;
          bus.ld_valid  = ~bus.req_we;
          state_d       = IDLE;
        end
      endcase
    end else if (rst) begin
      state_d = IDLE;
    end
  end

  assign bus.load_data = bus.ld_valid ? ext_data : 32'b0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      hold_q  <= 32'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_lsu_misalign.sv
// Directed bench for lsu_misalign with a behavioural word memory shared by two instances.
module tb_lsu_misalign;

  localparam int ADDR_W = 13;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  lsu_if #(.ADDR_W(ADDR_W)) bus ();
  lsu_if #(.ADDR_W(ADDR_W)) bus_nm ();

  lsu_misalign #(.ADDR_W(ADDR_W), .MISALIGN_EN(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  lsu_misalign #(.ADDR_W(ADDR_W), .MISALIGN_EN(0)) u_dut_nm (
    .clk (clk),
    .rst (rst),
    .bus (bus_nm.slave)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata    = mem[bus.mem_addr];
  assign bus_nm.mem_rdata = mem[bus_nm.mem_addr];

  always @(negedge clk) begin
    if (!bus.mem_cs && !bus.mem_wr)
      for (int b = 0; b < 4; b++)
        if (bus.mem_mask[b]) mem[bus.mem_addr][8*b +: 8] = bus.mem_wdata[8*b +: 8];
    if (!bus_nm.mem_cs && !bus_nm.mem_wr)
      for (int b = 0; b < 4; b++)
        if (bus_nm.mem_mask[b]) mem[bus_nm.mem_addr][8*b +: 8] = bus_nm.mem_wdata[8*b +: 8];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload();
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 32'h0;
    mem[0] = 32'h44332211;
    mem[1] = 32'h88776655;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    #2;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    #2;
  endtask

  task automatic load_expect(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] exp);
    tick();
    issue(1'b0, f3, addr, 32'h0);
    check({tag, " stall"}, {31'b0, bus.stall}, 32'h0);
    check({tag, " ld_valid"}, {31'b0, bus.ld_valid}, 32'h1);
    check({tag, " data"}, bus.load_data, exp);
  endtask

  task automatic fault_expect(input string tag, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr);
    tick();
    issue(we, f3, addr, 32'hDEADBEEF);
    check({tag, " fault"}, {31'b0, bus.fault}, 32'h1);
    check({tag, " cs"}, {31'b0, bus.mem_cs}, 32'h1);
    check({tag, " stall"}, {31'b0, bus.stall}, 32'h0);
    check({tag, " ld_valid"}, {31'b0, bus.ld_valid}, 32'h0);
  endtask

  initial begin
    preload();
    bus_nm.req_valid  = 1'b0;
    bus_nm.req_we     = 1'b0;
    bus_nm.req_funct3 = 3'd0;
    bus_nm.req_addr   = 32'h0;
    bus_nm.req_wdata  = 32'h0;

    // Reset forces outputs even with a request present.
    tick();
    issue(1'b0, 3'd2, 32'h4, 32'h0);
    check("rst cs", {31'b0, bus.mem_cs}, 32'h1);
    check("rst wr", {31'b0, bus.mem_wr}, 32'h1);
    check("rst mask", {28'b0, bus.mem_mask}, 32'h0);
    check("rst stall", {31'b0, bus.stall}, 32'h0);
    check("rst ld_valid", {31'b0, bus.ld_valid}, 32'h0);
    check("rst fault", {31'b0, bus.fault}, 32'h0);
    check("rst load_data", bus.load_data, 32'h0);
    tick();
    rst = 1'b1;
    idle();
    check("idle cs", {31'b0, bus.mem_cs}, 32'h1);
    check("idle mask", {28'b0, bus.mem_mask}, 32'h0);
    check("idle ld_valid", {31'b0, bus.ld_valid}, 32'h0);

    // Aligned and non-crossing loads.
    tick();
    issue(1'b0, 3'd2, 32'h4, 32'h0);
    check("LW4 addr", {19'b0, bus.mem_addr}, 32'h1);
    check("LW4 cs", {31'b0, bus.mem_cs}, 32'h0);
    check("LW4 wr", {31'b0, bus.mem_wr}, 32'h1);
    check("LW4 stall", {31'b0, bus.stall}, 32'h0);
    check("LW4 data", bus.load_data, 32'h88776655);
    check("LW4 ld_valid", {31'b0, bus.ld_valid}, 32'h1);
    load_expect("LB3", 3'd0, 32'h3, 32'h00000044);
    load_expect("LB7", 3'd0, 32'h7, 32'hFFFFFF88);
    load_expect("LBU7", 3'd4, 32'h7, 32'h00000088);
    load_expect("LH6", 3'd1, 32'h6, 32'hFFFF8877);
    load_expect("LHU6", 3'd5, 32'h6, 32'h00008877);
    load_expect("LH1", 3'd1, 32'h1, 32'h00003322);

    // Word-crossing load.
    tick();
    issue(1'b0, 3'd2, 32'h2, 32'h0);
    check("LW2 c0 stall", {31'b0, bus.stall}, 32'h1);
    check("LW2 c0 addr", {19'b0, bus.mem_addr}, 32'h0);
    check("LW2 c0 ld_valid", {31'b0, bus.ld_valid}, 32'h0);
    tick();
    #2;
    check("LW2 c1 stall", {31'b0, bus.stall}, 32'h0);
    check("LW2 c1 addr", {19'b0, bus.mem_addr}, 32'h1);
    check("LW2 c1 data", bus.load_data, 32'h66554433);
    check("LW2 c1 ld_valid", {31'b0, bus.ld_valid}, 32'h1);
    load_expect("LW0 after split", 3'd2, 32'h0, 32'h44332211);

    tick();
    issue(1'b0, 3'd1, 32'h3, 32'h0);
    check("LH3 c0 stall", {31'b0, bus.stall}, 32'h1);
    tick();
    #2;
    check("LH3 c1 data", bus.load_data, 32'h00005544);

    // Word-crossing store.
    tick();
    issue(1'b1, 3'd1, 32'h3, 32'h0000BEEF);
    check("SH3 c0 mask", {28'b0, bus.mem_mask}, 32'h8);
    check("SH3 c0 wdata", bus.mem_wdata, 32'hEF000000);
    check("SH3 c0 addr", {19'b0, bus.mem_addr}, 32'h0);
    check("SH3 c0 wr", {31'b0, bus.mem_wr}, 32'h0);
    check("SH3 c0 stall", {31'b0, bus.stall}, 32'h1);
    tick();
    #2;
    check("SH3 c1 mask", {28'b0, bus.mem_mask}, 32'h1);
    check("SH3 c1 wdata", bus.mem_wdata, 32'h000000BE);
    check("SH3 c1 addr", {19'b0, bus.mem_addr}, 32'h1);
    check("SH3 c1 stall", {31'b0, bus.stall}, 32'h0);
    load_expect("SH3 rb w0", 3'd2, 32'h0, 32'hEF332211);
    load_expect("SH3 rb w1", 3'd2, 32'h4, 32'h887766BE);

    // Aligned byte store.
    tick();
    issue(1'b1, 3'd0, 32'h5, 32'h000000AB);
    check("SB5 mask", {28'b0, bus.mem_mask}, 32'h2);
    check("SB5 wdata", bus.mem_wdata, 32'h0000AB00);
    check("SB5 stall", {31'b0, bus.stall}, 32'h0);
    load_expect("SB5 rb", 3'd0, 32'h5, 32'hFFFFFFAB);

    // Reset asserted while in the second half of a split access.
    tick();
    preload();
    idle();
    tick();
    issue(1'b0, 3'd2, 32'h2, 32'h0);
    check("RS c0 stall", {31'b0, bus.stall}, 32'h1);
    tick();
    rst = 1'b0;
    #2;
    check("RS c1 cs", {31'b0, bus.mem_cs}, 32'h1);
    check("RS c1 stall", {31'b0, bus.stall}, 32'h0);
    check("RS c1 ld_valid", {31'b0, bus.ld_valid}, 32'h0);
    tick();
    rst = 1'b1;
    #2;
    check("RS c2 stall", {31'b0, bus.stall}, 32'h1);
    check("RS c2 addr", {19'b0, bus.mem_addr}, 32'h0);
    tick();
    #2;
    check("RS c3 data", bus.load_data, 32'h66554433);
    check("RS c3 ld_valid", {31'b0, bus.ld_valid}, 32'h1);

    // Faults.
    fault_expect("LW7FFE", 1'b0, 3'd2, 32'h00007FFE);
    fault_expect("SW8000", 1'b1, 3'd2, 32'h00008000);
    fault_expect("LDF3_3", 1'b0, 3'd3, 32'h00000000);
    fault_expect("STF3_4", 1'b1, 3'd4, 32'h00000000);
    tick();
    idle();
    bus_nm.req_valid  = 1'b1;
    bus_nm.req_we     = 1'b0;
    bus_nm.req_funct3 = 3'd1;
    bus_nm.req_addr   = 32'h3;
    #1;
    check("NM LH3 fault", {31'b0, bus_nm.fault}, 32'h1);
    check("NM LH3 cs", {31'b0, bus_nm.mem_cs}, 32'h1);
    check("NM LH3 stall", {31'b0, bus_nm.stall}, 32'h0);
    tick();
    bus_nm.req_addr = 32'h2;
    #2;
    check("NM LH2 fault", {31'b0, bus_nm.fault}, 32'h0);
    check("NM LH2 data", bus_nm.load_data, 32'h00004433);
    tick();
    bus_nm.req_valid = 1'b0;
    #2;
    check("fault mem w0", mem[0], 32'h44332211);
    check("fault mem w1", mem[1], 32'h88776655);
    check("fault mem last", mem[(1<<ADDR_W)-1], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
